prog_delay_timer: RTL
=====================

PROG_DELAY_TIMER -- requirements
Module: prog_delay_timer

Interface
REQ-001 Parameter CNT_W, default 14, width of delay count and per-channel N.
REQ-002 Parameter NCH, default 4, number of independent timer channels.
REQ-003 Parameter PSC_W, default 8, prescaler width (used only with REQ-030).
REQ-004 clk  input  1  sole clock; all state SHALL change on rising edge only.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 n_in  input  NCH*CNT_W  per-channel delay N; channel c occupies bits [c*CNT_W +: CNT_W].
REQ-007 mode  input  2*NCH  per-channel mode; channel c occupies bits [2c +: 2].
REQ-008 trigger  input  NCH  per-channel trigger level.
REQ-009 time_out  output  NCH  per-channel timeout indication, registered.
REQ-010 busy  output  NCH  high while channel is in COUNT, registered.

Function
REQ-011 Each channel SHALL run an independent FSM with states IDLE, COUNT and DONE, plus a CNT_W-bit counter and a latched copy of N.
REQ-012 An "active edge" SHALL be a rising clk edge on which the advance tick is high; without REQ-030 every edge is active.
REQ-013 N SHALL be latched on IDLE->COUNT; later changes to n_in or mode SHALL not affect a run in progress; N=0 SHALL be treated as N=1.
REQ-014 Mode 0 LEVEL: IDLE->COUNT when trigger is high; time_out SHALL rise on the Nth consecutive active edge with trigger high, then DONE; DONE holds time_out high until trigger is low; trigger low in any state -> IDLE with time_out=0 and count=0 on that edge.
REQ-015 Mode 1 ONESHOT: a rising trigger (low on the previous edge, high on this one) in IDLE starts COUNT; trigger is then ignored; on the Nth active edge time_out SHALL pulse high for exactly one clk cycle, then IDLE.
REQ-016 Mode 2 RETRIG: as ONESHOT, but a trigger rising edge during COUNT SHALL reset count to 0, and that edge counts as active edge 1 of a new run.
REQ-017 Mode 3 PERIODIC: while trigger is high, time_out SHALL pulse for one cycle on every Nth active edge; trigger low -> IDLE with count cleared.
REQ-018 Counter compare SHALL be count == N_latched-1, with count cleared on match; count SHALL never wrap past N_latched-1.
REQ-019 A per-channel trigger history register SHALL provide edge detection; its reset value is 0, so a trigger held high through reset release counts as a rising edge.
REQ-020 Channels SHALL not interact; simultaneous events on different channels SHALL be handled in the same cycle.
REQ-021 busy SHALL equal (state == COUNT) one cycle after the transition edge, i.e. registered alongside the state.

Reset
REQ-022 rst_n low at a rising edge SHALL force all channels to IDLE, count=0, N_latched=0, trigger history=0, time_out=0 and busy=0.
REQ-023 Reset mid-run SHALL abort the run with no time_out pulse; the first edge with rst_n high SHALL be evaluated normally.

Configuration
REQ-030 PROG_DELAY_TIMER_PRESCALE_EN defined: add input psc [PSC_W-1:0]; a shared prescaler counts 0..psc and wraps; the tick is high on the edge where the prescaler equals psc (psc=0 gives a tick on every edge); the prescaler clears on reset and, via the tick, paces the counters of all channels.
REQ-031 PROG_DELAY_TIMER_PRESCALE_EN undefined: no psc port and no prescaler logic; the tick is constant 1.
REQ-032 Edge detection, trigger-low abort and time_out pulse width (one clk) SHALL be independent of the tick in both builds.

Structure
REQ-040 Shared package prog_delay_timer_pkg SHALL hold the mode encodings (LEVEL=0, ONESHOT=1, RETRIG=2, PERIODIC=3) and the FSM state typedef.
REQ-041 Sub-module delay_timer_chan SHALL implement one channel; the top SHALL instantiate NCH copies via generate and contain the shared prescaler.

Verification
REQ-050 LEVEL, N=5: trigger high from edge 0 -> time_out high after edge 4 and held; trigger low at edge 9 -> time_out low after edge 9.
REQ-051 ONESHOT, N=3: trigger rise at edge 0 held for 10 cycles -> single 1-cycle pulse after edge 2; no further pulses; busy high after edges 0-1.
REQ-052 RETRIG, N=4: rises at edges 0 and 2 -> pulse only after edge 5.
REQ-053 PERIODIC, N=2, channels 0 and 3 triggered together -> both pulse after edges 1, 3, 5; channels 1 and 2 stay 0.
REQ-054 rst_n low at edge 2 of a LEVEL N=5 run -> no time_out; N=0 in ONESHOT -> pulse after the start edge.
REQ-055 PRESCALE_EN, psc=2, ONESHOT N=2 -> pulse delay of 6 clk cycles (±2 by prescaler phase); with psc=0 behaviour matches the undefined build.

Source files
------------

// File: rtl/prog_delay_timer_pkg.sv
// prog_delay_timer_pkg -- shared encodings for the programmable delay timer.
//   mode_e  : per-channel operating mode as driven on the mode port
//   state_e : per-channel FSM state
//   is_level_start : modes that start (and abort) on trigger level rather than edge
package prog_delay_timer_pkg;

  typedef enum logic [1:0] {
    LEVEL    = 2'd0,
    ONESHOT  = 2'd1,
    RETRIG   = 2'd2,
    PERIODIC = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DONE  = 2'd2
  } state_e;

  function automatic logic is_level_start(mode_e m);
    return (m == LEVEL) || (m == PERIODIC);
  endfunction

endpackage

// File: rtl/delay_timer_chan.sv
// delay_timer_chan -- one independent timer channel.
//   clk, rst_n : clock, synchronous active-low reset
//   tick       : advance enable; only edges with tick high are counted
//   trigger    : channel trigger level
//   n          : delay length (0 behaves as 1), latched when a run starts
//   mode       : mode_e encoding, latched when a run starts
//   time_out   : registered timeout indication
//   busy       : registered, high while the FSM sits in COUNT
module delay_timer_chan
  import prog_delay_timer_pkg::*;
#(
  parameter int CNT_W = 14
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick,
  input  logic             trigger,
  input  logic [CNT_W-1:0] n,
  input  logic [1:0]       mode,
  output logic             time_out,
  output logic             busy
);

  state_e           state_q, state_d;
  mode_e            mode_q, mode_d, mode_in;
  logic [CNT_W-1:0] cnt_q, cnt_d, n_q, n_d, n_lim;
  logic             trig_q, rise, last, first_hit, re_hit, to_d;

  assign mode_in = mode_e'(mode);
  assign rise    = trigger & ~trig_q;
  // Terminal count is N-1, with a stored N of 0 treated as 1.
  assign n_lim   = (n_q == '0) ? '0 : n_q - CNT_W'(1);
  assign last    = (cnt_q == n_lim);
  // The edge that starts (or restarts) a run is itself active edge 1, so a
  // run of length 1 completes on that same edge when tick is high.
  assign first_hit = tick && (n <= CNT_W'(1));
  assign re_hit    = tick && (n_q <= CNT_W'(1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    n_d     = n_q;
    mode_d  = mode_q;
    to_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (is_level_start(mode_in) ? trigger : rise) begin
          n_d    = n;
          mode_d = mode_in;
          if (first_hit) begin
            to_d  = 1'b1;
            cnt_d = '0;
            case (mode_in)
              LEVEL:    state_d = DONE;
              PERIODIC: state_d = COUNT;
              default:  state_d = IDLE;
            endcase
          end else begin
            cnt_d   = CNT_W'(tick);
            state_d = COUNT;
          end
        end
      end
      COUNT: begin
        if (is_level_start(mode_q) && !trigger) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (mode_q == RETRIG && rise) begin
          if (re_hit) begin
            to_d    = 1'b1;
            cnt_d   = '0;
            state_d = IDLE;
          end else begin
            cnt_d = CNT_W'(tick);
          end
        end else if (tick) begin
          if (last) begin
            to_d  = 1'b1;
            cnt_d = '0;
            case (mode_q)
              LEVEL:    state_d = DONE;
              PERIODIC: state_d = COUNT;
              default:  state_d = IDLE;
            endcase
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      DONE: begin
        // Only LEVEL runs reach DONE: hold the timeout while trigger stays high.
        if (trigger) to_d = 1'b1;
        else         state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      n_q      <= '0;
      mode_q   <= LEVEL;
      trig_q   <= 1'b0;
      time_out <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      n_q      <= n_d;
      mode_q   <= mode_d;
      trig_q   <= trigger;
      time_out <= to_d;
      busy     <= (state_d == COUNT);
    end
  end

endmodule

// File: rtl/prog_delay_timer.sv
// prog_delay_timer -- NCH independent programmable delay timers.
//   clk, rst_n : clock, synchronous active-low reset
//   psc        : prescaler terminal value (only with PROG_DELAY_TIMER_PRESCALE_EN)
//   n_in       : per-channel delay, channel c at [c*CNT_W +: CNT_W]
//   mode       : per-channel mode, channel c at [2c +: 2]
//   trigger    : per-channel trigger level
//   time_out   : per-channel registered timeout
//   busy       : per-channel registered "counting" flag
// Build option PROG_DELAY_TIMER_PRESCALE_EN adds a shared prescaler that
// paces counting in every channel; without it every edge advances counters.
module prog_delay_timer
  import prog_delay_timer_pkg::*;
#(
  parameter int CNT_W = 14,
  parameter int NCH   = 4,
  parameter int PSC_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
`ifdef PROG_DELAY_TIMER_PRESCALE_EN
  input  logic [PSC_W-1:0]     psc,
`endif
  input  logic [NCH*CNT_W-1:0] n_in,
  input  logic [2*NCH-1:0]     mode,
  input  logic [NCH-1:0]       trigger,
  output logic [NCH-1:0]       time_out,
  output logic [NCH-1:0]       busy
);

  if (PSC_W < 1) begin : g_bad_psc_w
    $error("PSC_W must be at least 1");
  end

  logic tick;

`ifdef PROG_DELAY_TIMER_PRESCALE_EN
  logic [PSC_W-1:0] psc_cnt;

  // >= rather than == so that lowering psc below the current count wraps
  // on the next edge instead of running the full counter range.
  assign tick = (psc_cnt >= psc);

  always_ff @(posedge clk) begin
    if (!rst_n)    psc_cnt <= '0;
    else if (tick) psc_cnt <= '0;
    else           psc_cnt <= psc_cnt + PSC_W'(1);
  end
`else
  assign tick = 1'b1;
`endif

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    delay_timer_chan #(.CNT_W(CNT_W)) u_chan (
      .clk      (clk),
      .rst_n    (rst_n),
      .tick     (tick),
      .trigger  (trigger[c]),
      .n        (n_in[c*CNT_W +: CNT_W]),
      .mode     (mode[2*c +: 2]),
      .time_out (time_out[c]),
      .busy     (busy[c])
    );
  end

endmodule
